// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Instruction fetch front end for a 1024 x 32 combinational-read instruction
// memory. A program counter drives imem_addr directly; the word returned on
// imem_data in the same cycle is captured into instr_out on the next rising
// edge, together with the address it came from (instr_pc).
//
// Sequencing is controlled by a three-state FSM (IDLE, RUN, HALTED) that is
// exported on the state port. In RUN, each cycle resolves exactly one action
// in priority order: halt request, redirect, stall, halt-word detection,
// normal fetch.
//
// Handshake: instr_valid/instr_out/instr_pc form the presentation side and
// stall is the downstream "not ready" signal. While stall is high (and no
// halt or redirect is present) the presented word, its PC, instr_valid and
// the fetch PC are all held, so a word shown with instr_valid=1 during a
// stall is the same word that will still be shown when stall drops. A word
// counts as accepted (fetch_count) on the edge where it is captured.
//
// Parameters
//   BOOT_ADDR  PC loaded whenever start launches sequencing.
//   HALT_WORD  fetched word that stops sequencing without being presented.
//
// Ports
//   clk              sole clock, all state updates on the rising edge
//   reset            asynchronous, active-high; clears all state
//   start            IDLE/HALTED -> RUN, PC <= BOOT_ADDR (ignored in RUN)
//   halt             external stop request (RUN -> HALTED)
//   stall            downstream not ready; hold fetch
//   redirect_valid   branch/jump taken; PC <= redirect_target, one bubble
//   redirect_target  new PC
//   imem_addr        word address to instruction memory (= PC)
//   imem_data        word at imem_addr, same cycle
//   instr_out        registered fetched word
//   instr_pc         address of instr_out
//   instr_valid      instr_out holds a live instruction
//   state            00 IDLE, 01 RUN, 10 HALTED
//   wrap_flag        sticky: PC wrapped 1023 -> 0 since the last start
//   fetch_count      saturating count of accepted fetches
// -----------------------------------------------------------------------------
module fetch_sequencer #(
  parameter logic [9:0]  BOOT_ADDR = 10'd0,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        halt,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [9:0]  redirect_target,
  output logic [9:0]  imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] instr_out,
  output logic [9:0]  instr_pc,
  output logic        instr_valid,
  output logic [1:0]  state,
  output logic        wrap_flag,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_HALTED = 2'b10
  } state_t;

  localparam logic [9:0]  PC_LAST   = 10'd1023;
  localparam logic [15:0] COUNT_MAX = 16'hFFFF;

  // Registered state
  state_t      cur_state;
  logic [9:0]  pc_q;
  logic [31:0] instr_q;
  logic [9:0]  instr_pc_q;
  logic        valid_q;
  logic        wrap_q;
  logic [15:0] count_q;

  // Next-state values
  state_t      nxt_state;
  logic [9:0]  pc_d;
  logic [31:0] instr_d;
  logic [9:0]  instr_pc_d;
  logic        valid_d;
  logic        wrap_d;
  logic [15:0] count_d;

  // Decoded per-cycle actions in RUN, already resolved by priority so that
  // at most one of them is true in any cycle.
  logic run_halt;
  logic run_redirect;
  logic run_stall;
  logic run_halt_word;
  logic run_fetch;
  logic launch;

  always_comb begin
    run_halt      = 1'b0;
    run_redirect  = 1'b0;
    run_stall     = 1'b0;
    run_halt_word = 1'b0;
    run_fetch     = 1'b0;
    if (cur_state == ST_RUN) begin
      if (halt) begin
        run_halt = 1'b1;
      end else if (redirect_valid) begin
        run_redirect = 1'b1;
      end else if (stall) begin
        run_stall = 1'b1;
      end else if (imem_data == HALT_WORD) begin
        run_halt_word = 1'b1;
      end else begin
        run_fetch = 1'b1;
      end
    end
  end

  // start only has an effect from IDLE or HALTED; in RUN it is ignored.
  assign launch = start && ((cur_state == ST_IDLE) || (cur_state == ST_HALTED));

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state <= ST_IDLE;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    nxt_state  = cur_state;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    wrap_d     = wrap_q;
    count_d    = count_q;

    case (cur_state)
      ST_IDLE, ST_HALTED: begin
        // Nothing is presented outside RUN; everything else stays frozen
        // until a start relaunches from BOOT_ADDR with fresh status.
        valid_d = 1'b0;
        if (launch) begin
          nxt_state = ST_RUN;
          pc_d      = BOOT_ADDR;
          wrap_d    = 1'b0;
          count_d   = 16'd0;
        end
      end

      ST_RUN: begin
        if (run_halt) begin
          nxt_state = ST_HALTED;
          valid_d   = 1'b0;
        end else if (run_redirect) begin
          // The word at the old PC is dropped, leaving one bubble.
          pc_d    = redirect_target;
          valid_d = 1'b0;
        end else if (run_stall) begin
          // Hold everything.
          valid_d = valid_q;
        end else if (run_halt_word) begin
          // PC stays on the halt word so a debugger can see where it stopped.
          nxt_state = ST_HALTED;
          valid_d   = 1'b0;
        end else if (run_fetch) begin
          instr_d    = imem_data;
          instr_pc_d = pc_q;
          valid_d    = 1'b1;
          pc_d       = pc_q + 10'd1;
          if (pc_q == PC_LAST) begin
            wrap_d = 1'b1;
          end
          if (count_q != COUNT_MAX) begin
            count_d = count_q + 16'd1;
          end
        end
      end

      default: begin
        // Unused encoding: recover to IDLE without presenting anything.
        nxt_state = ST_IDLE;
        valid_d   = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= 10'd0;
      instr_q    <= 32'd0;
      instr_pc_q <= 10'd0;
      valid_q    <= 1'b0;
      wrap_q     <= 1'b0;
      count_q    <= 16'd0;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      wrap_q     <= wrap_d;
      count_q    <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign imem_addr   = pc_q;
  assign instr_out   = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;
  assign state       = cur_state;
  assign wrap_flag   = wrap_q;
  assign fetch_count = count_q;

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter BOOT_ADDR, default 10'd0, PC loaded on start.
REQ-002 SHALL have parameter HALT_WORD, default 32'hFFFF_FFFF, fetched word that stops sequencing.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high.
REQ-005 SHALL have port start  input  1  IDLE/HALTED -> RUN, PC <= BOOT_ADDR.
REQ-006 SHALL have port halt  input  1  external stop request.
REQ-007 SHALL have port stall  input  1  downstream not ready; hold fetch.
REQ-008 SHALL have port redirect_valid  input  1  branch/jump taken.
REQ-009 SHALL have port redirect_target  input  10  new PC.
REQ-010 SHALL have port imem_addr  output  10  word address to instruction memory (combinational-read, 1024x32).
REQ-011 SHALL have port imem_data  input  32  word at imem_addr, same cycle.
REQ-012 SHALL have port instr_out  output  32  registered fetched word.
REQ-013 SHALL have port instr_pc  output  10  address of instr_out.
REQ-014 SHALL have port instr_valid  output  1  instr_out holds a live instruction.
REQ-015 SHALL have port state  output  2  00 IDLE, 01 RUN, 10 HALTED.
REQ-016 SHALL have port wrap_flag  output  1  sticky: PC wrapped 1023 -> 0.
REQ-017 SHALL have port fetch_count  output  16  saturating count of accepted fetches.

Function
REQ-018 SHALL hold PC register; imem_addr = PC combinationally in all states.
REQ-019 IDLE: instr_valid 0, PC unchanged; start -> RUN, PC <= BOOT_ADDR, wrap_flag and fetch_count cleared.
REQ-020 RUN, no stall/redirect/halt: instr_out <= imem_data, instr_pc <= PC, instr_valid <= 1, PC <= PC+1, fetch_count +1; one-cycle latency from address to instr_out.
REQ-021 PC increment SHALL be modulo 1024; 1023 -> 0 sets wrap_flag, sequencing continues.
REQ-022 RUN with stall=1 (no redirect): PC, instr_out, instr_pc, instr_valid, fetch_count all held.
REQ-023 RUN with redirect_valid=1: PC <= redirect_target, instr_valid <= 0 (one bubble), fetch_count unchanged; redirect SHALL override stall same cycle.
REQ-024 RUN with halt=1: state <= HALTED, instr_valid <= 0, PC held; halt SHALL override redirect and stall.
REQ-025 RUN, accepted fetch with imem_data == HALT_WORD: word SHALL NOT be presented (instr_valid <= 0), state <= HALTED, PC held at HALT_WORD address, fetch_count unchanged.
REQ-026 HALTED: outputs frozen except instr_valid 0; start -> RUN as in REQ-019; redirect/stall ignored.
REQ-027 start while in RUN SHALL be ignored.
REQ-028 fetch_count SHALL saturate at 16'hFFFF.
REQ-029 Priority per cycle in RUN: halt > redirect > stall > HALT_WORD detect > normal fetch.
REQ-030 state encoding 11 SHALL be unreachable; if entered, next state IDLE.

Reset
REQ-031 reset=1 SHALL immediately (no clock) force state IDLE, PC 0, instr_out 0, instr_pc 0, instr_valid 0, wrap_flag 0, fetch_count 0.
REQ-032 Reset mid-RUN SHALL abandon in-flight fetch; first post-reset fetch requires start.
REQ-033 Deassertion of reset SHALL take effect at next rising clk; no fetch in that cycle unless start.

Verification
REQ-034 reset, start, memory words 0..4 = 0x11..0x15 -> instr_valid rises one cycle after start, instr_out 0x11,0x12,... with instr_pc 0,1,2; fetch_count 3 after 3 fetches.
REQ-035 stall high 3 cycles at PC=2 -> instr_out/instr_pc/fetch_count frozen; resume yields PC 2 word next, no skip or duplicate valid.
REQ-036 redirect_target=100 with stall=1 at PC=5 -> next cycle instr_valid 0, imem_addr 100; following cycle instr_pc 100.
REQ-037 BOOT_ADDR=1022, no halt word -> pc sequence 1022,1023,0; wrap_flag 1 from cycle after 1023 fetch until reset or start.
REQ-038 word 0xFFFF_FFFF at address 3 -> instr_pc stops at 2, state 10, instr_valid 0; halt and redirect same cycle -> HALTED, PC unchanged.
REQ-039 reset asserted asynchronously mid-RUN between edges -> all outputs zero before next edge; start re-fetches from BOOT_ADDR.
